// File: rtl/axis_csum_append.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_csum_append: AXI-Stream pass-through that appends a one-beat         |
// | checksum (sum or XOR) per frame. Option macro: CSUM_INVERT_EN.            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module axis_csum_append #(
  parameter int DATA_W   = 8,
  parameter int CSUM_XOR = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [CNT_W-1:0]  C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] C_DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    PASS   = 1'b0,
    APPEND = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_csum;
  logic [DATA_W-1:0] r_m_tdata;
  logic              r_m_tvalid;
  logic              r_m_tlast;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [DATA_W-1:0] w_acc_next;
  logic [DATA_W-1:0] w_csum_out;
  logic              w_slot_free;
  logic              w_s_tready;
  logic              w_accept;
  logic              w_load_csum;

  assign w_slot_free = !r_m_tvalid || m_tready;

  generate
    if (CSUM_XOR != 0) begin : g_acc_xor
      assign w_acc_next = r_acc ^ s_tdata;
    end else begin : g_acc_sum
      assign w_acc_next = r_acc + s_tdata;
    end
  endgenerate

`ifdef CSUM_INVERT_EN
  // Inverted form makes the whole output frame fold to 0 (sum) or all-ones (XOR).
  generate
    if (CSUM_XOR != 0) begin : g_inv_xor
      assign w_csum_out = ~r_csum;
    end else begin : g_inv_sum
      assign w_csum_out = ~r_csum + C_DATA_ONE;
    end
  endgenerate
`else
  assign w_csum_out = r_csum;
`endif

  always_comb begin
    w_state_next = r_state;
    w_s_tready   = 1'b0;
    w_accept     = 1'b0;
    w_load_csum  = 1'b0;
    case (r_state)
      PASS: begin
        w_s_tready = reset && w_slot_free;
        w_accept   = s_tvalid && w_s_tready;
        if (w_accept && s_tlast) begin
          w_state_next = APPEND;
        end
      end
      APPEND: begin
        w_load_csum = w_slot_free;
        if (w_slot_free) begin
          w_state_next = PASS;
        end
      end
      default: w_state_next = PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= PASS;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc       <= '0;
      r_csum      <= '0;
      r_m_tdata   <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (r_m_tvalid && m_tready && r_m_tlast) begin
        r_frame_cnt <= r_frame_cnt + C_CNT_ONE;
      end
      if (w_accept) begin
        r_m_tdata  <= s_tdata;
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= 1'b0;
        r_acc      <= w_acc_next;
        if (s_tlast) begin
          r_csum <= w_acc_next;
        end
      end else if (w_load_csum) begin
        r_m_tdata  <= w_csum_out;
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= 1'b1;
        r_acc      <= '0;
      end else if (w_slot_free) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign s_tready  = w_s_tready;
  assign m_tdata   = r_m_tdata;
  assign m_tvalid  = r_m_tvalid;
  assign m_tlast   = r_m_tlast;
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axis_csum_append.sv
`default_nettype none
// Bench for axis_csum_append: sum (instance a) and XOR with 3-bit counter (instance b) against a frame-level model.
module tb_axis_csum_append;

  logic        clk;
  logic        reset;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        m_tready;
  logic        a_s_tready, b_s_tready;
  logic [7:0]  a_m_tdata, b_m_tdata;
  logic        a_m_tvalid, b_m_tvalid;
  logic        a_m_tlast, b_m_tlast;
  logic [15:0] a_frame_cnt;
  logic [2:0]  b_frame_cnt;

  int   checks = 0;
  int   errors = 0;
  bit   rdy_mode = 0;
  bit   rdy_force = 1;
  bit   gap_mode = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic [7:0] cur[$];
  logic [7:0] obs_a[$];
  logic [7:0] obs_b[$];
  int   cnt_a = 0;
  int   cnt_b = 0;
  bit   pend = 0;
  bit   held = 0;
  logic [8:0] held_a, held_b;
  logic [8:0] exp_beat;
  logic       exp_rdy;

  axis_csum_append #(.DATA_W(8), .CSUM_XOR(0), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(a_s_tready), .s_tlast(s_tlast),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(m_tready), .m_tlast(a_m_tlast),
    .frame_cnt(a_frame_cnt)
  );

  axis_csum_append #(.DATA_W(8), .CSUM_XOR(1), .CNT_W(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(b_s_tready), .s_tlast(s_tlast),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(m_tready), .m_tlast(b_m_tlast),
    .frame_cnt(b_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pick(input logic [7:0] plain, input logic [7:0] inv);
`ifdef CSUM_INVERT_EN
    return inv;
`else
    return plain;
`endif
  endfunction

  // Checksum of the frame collected so far, from plain integer arithmetic.
  function automatic logic [7:0] frame_csum(input bit use_xor);
    int acc;
    acc = 0;
    foreach (cur[i]) acc = use_xor ? (acc ^ int'(cur[i])) : (acc + int'(cur[i]));
    acc = acc % 256;
`ifdef CSUM_INVERT_EN
    acc = use_xor ? (255 - acc) : ((256 - acc) % 256);
`endif
    return acc[7:0];
  endfunction

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      m_tready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Scoreboard / protocol monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        qa.delete(); qb.delete(); cur.delete();
        cnt_a = 0; cnt_b = 0; pend = 0; held = 0;
      end else begin
        exp_rdy = !pend && (!a_m_tvalid || m_tready);
        chk("a_s_tready", a_s_tready, exp_rdy);
        chk("b_s_tready", b_s_tready, exp_rdy);
        if (held) begin
          chk("a_hold", {a_m_tvalid, a_m_tlast, a_m_tdata}, {1'b1, held_a});
          chk("b_hold", {b_m_tvalid, b_m_tlast, b_m_tdata}, {1'b1, held_b});
        end
        chk("a_frame_cnt", a_frame_cnt, cnt_a);
        chk("b_frame_cnt", b_frame_cnt, cnt_b);
        if (a_m_tvalid && m_tready) begin
          chk("a_beat_expected", qa.size() != 0, 1);
          if (qa.size() != 0) begin
            exp_beat = qa.pop_front();
            chk("a_beat", {a_m_tlast, a_m_tdata}, exp_beat);
            if (a_m_tlast) obs_a.push_back(a_m_tdata);
            if (exp_beat[8]) cnt_a = (cnt_a + 1) % 65536;
          end
        end
        if (b_m_tvalid && m_tready) begin
          chk("b_beat_expected", qb.size() != 0, 1);
          if (qb.size() != 0) begin
            exp_beat = qb.pop_front();
            chk("b_beat", {b_m_tlast, b_m_tdata}, exp_beat);
            if (b_m_tlast) obs_b.push_back(b_m_tdata);
            if (exp_beat[8]) cnt_b = (cnt_b + 1) % 8;
          end
        end
        if (pend && (!a_m_tvalid || m_tready)) pend = 0;
        if (s_tvalid && a_s_tready) begin
          cur.push_back(s_tdata);
          qa.push_back({1'b0, s_tdata});
          qb.push_back({1'b0, s_tdata});
          if (s_tlast) begin
            qa.push_back({1'b1, frame_csum(1'b0)});
            qb.push_back({1'b1, frame_csum(1'b1)});
            cur.delete();
            pend = 1;
          end
        end
        held   = a_m_tvalid && !m_tready;
        held_a = {a_m_tlast, a_m_tdata};
        held_b = {b_m_tlast, b_m_tdata};
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    if (gap_mode) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (a_s_tready || n > 200) break;
      n++;
    end
    chk("accept_timeout", n > 200, 0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy_mode = 0; rdy_force = 1;
    while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n >= 300, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int len;
    reset = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_a_out", {a_s_tready, a_m_tvalid, a_m_tlast, a_m_tdata}, 0);
    chk("rst_b_out", {b_s_tready, b_m_tvalid, b_m_tlast, b_m_tdata}, 0);
    chk("rst_cnt", {a_frame_cnt, b_frame_cnt}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 1);
    drain();
    chk("t1_a_csum", obs_a[$], pick(8'h06, 8'hFA));
    chk("t1_b_csum", obs_b[$], pick(8'h00, 8'hFF));
    chk("t1_a_cnt", a_frame_cnt, 1);

    send_byte(8'h0F, 0); send_byte(8'hF0, 0); send_byte(8'hAA, 1);
    drain();
    chk("t2_a_csum", obs_a[$], pick(8'hA9, 8'h57));
    chk("t2_b_csum", obs_b[$], pick(8'h55, 8'hAA));

    rdy_force = 0;
    send_byte(8'h80, 1);
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold_a", {a_m_tvalid, a_m_tdata, a_s_tready}, {1'b1, 8'h80, 1'b0});
    end
    @(posedge clk);
    #1;
    drain();
    chk("t3_a_csum", obs_a[$], pick(8'h80, 8'h80));
    chk("t3_b_csum", obs_b[$], pick(8'h80, 8'h7F));

    gap_mode = 1; rdy_mode = 1;
    send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 1);
    send_byte(8'h10, 1);
    drain();
    chk("t4_a_csum1", obs_a[$-1], pick(8'hFD, 8'h03));
    chk("t4_b_csum1", obs_b[$-1], pick(8'hFF, 8'h00));
    chk("t4_a_csum2", obs_a[$], pick(8'h10, 8'hF0));
    chk("t4_b_csum2", obs_b[$], pick(8'h10, 8'hEF));

    gap_mode = 0;
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("t5_rst_a_out", {a_s_tready, a_m_tvalid, a_m_tlast, a_m_tdata}, 0);
    chk("t5_rst_b_out", {b_s_tready, b_m_tvalid, b_m_tlast, b_m_tdata}, 0);
    chk("t5_rst_cnt", {a_frame_cnt, b_frame_cnt}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_byte(8'h05, 1);
    drain();
    chk("t5_a_csum", obs_a[$], pick(8'h05, 8'hFB));
    chk("t5_b_csum", obs_b[$], pick(8'h05, 8'hFA));
    chk("t5_a_cnt", a_frame_cnt, 1);
    chk("t5_b_cnt", b_frame_cnt, 1);

    gap_mode = 1;
    for (int f = 0; f < 20; f++) begin
      rdy_mode = 1;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) send_byte(8'($urandom), k == len - 1);
    end
    drain();
    chk("t6_a_cnt", a_frame_cnt, 21);
    chk("t6_b_cnt", b_frame_cnt, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
